// File: rtl/alu_pkg.sv
// Shared ALU definitions: serial adder FSM state encoding and ADD/SUB opcode values.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/fulladd.sv
// Single-bit full adder cell, used as the time-shared bit-slice of the serial adder.
module fulladd (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial ADD/SUB execution path: one fulladd cell walked LSB-first over WIDTH cycles,
// result and flags registered on completion with a one-cycle done pulse.
module serial_add_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_co;
  logic             last;
  logic [WIDTH-1:0] acc_nxt;

  fulladd u_fa (
    .a    (opa[0]),
    .b    (opb[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_co)
  );

  assign last    = (cnt == CW'(WIDTH - 1));
  assign acc_nxt = {fa_s, acc[WIDTH-1:1]};
  assign busy    = (state == RUN);
  assign done    = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      opa      <= '0;
      opb      <= '0;
      acc      <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (start) begin
            opa   <= a;
            opb   <= (op_sub == OP_SUB) ? ~b : b;
            carry <= op_sub;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          acc   <= acc_nxt;
          carry <= fa_co;
          cnt   <= cnt + 1'b1;
          // On the MSB slice the live carry is the carry into the MSB, so overflow is taken here.
          if (last) begin
            state    <= DONE;
            result   <= acc_nxt;
            cout     <= fa_co;
            overflow <= carry ^ fa_co;
            zero     <= (acc_nxt == '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (WIDTH = 8).
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       op_sub = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       cout;
  logic       overflow;
  logic       zero;

  int total = 0;
  int bad   = 0;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op_sub   (op_sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  // Called at a negedge (cycle 0); returns at the negedge of cycle 1.
  task automatic launch(input logic [7:0] x, input logic [7:0] y, input logic s);
    a      = x;
    b      = y;
    op_sub = s;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Starting in cycle 'first', waits (bounded) for done; reports its cycle number
  // (0 on timeout) and whether busy was high every cycle before it and low with it.
  task automatic wait_done(input int first, output int cyc, output bit busy_ok);
    busy_ok = 1'b1;
    cyc     = 0;
    for (int i = first; i <= 30; i++) begin
      if (done) begin
        cyc = i;
        if (busy) busy_ok = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, result, cout, overflow, zero} !== 13'h0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=%h", {busy, done, result, cout, overflow, zero}, 13'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({busy, done} !== 2'b00) begin
      bad++;
      $display("FAIL reset_idle busy_done got=%b exp=00", {busy, done});
    end
  endtask

  task automatic test_arith();
    logic [7:0] va [6] = '{8'h35, 8'hFF, 8'h7F, 8'h80, 8'h05, 8'h07};
    logic [7:0] vb [6] = '{8'h4A, 8'h01, 8'h01, 8'h01, 8'h07, 8'h07};
    logic       vs [6] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1};
    logic [7:0] er [6] = '{8'h7F, 8'h00, 8'h80, 8'h7F, 8'hFE, 8'h00};
    logic       ec [6] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1};
    logic       ev [6] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0};
    logic       ez [6] = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1};
    int cyc;
    bit bok;
    for (int k = 0; k < 6; k++) begin
      launch(va[k], vb[k], vs[k]);
      wait_done(1, cyc, bok);
      total++;
      if (cyc !== 9) begin
        bad++;
        $display("FAIL arith%0d done_cycle got=%0d exp=9", k, cyc);
      end
      total++;
      if (bok !== 1'b1) begin
        bad++;
        $display("FAIL arith%0d busy_window got=%b exp=1", k, bok);
      end
      total++;
      if (result !== er[k]) begin
        bad++;
        $display("FAIL arith%0d result got=%h exp=%h", k, result, er[k]);
      end
      total++;
      if ({cout, overflow, zero} !== {ec[k], ev[k], ez[k]}) begin
        bad++;
        $display("FAIL arith%0d flags_cvz got=%b exp=%b", k, {cout, overflow, zero}, {ec[k], ev[k], ez[k]});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_busy_ignore();
    int cyc;
    bit bok;
    launch(8'h12, 8'h34, 1'b0);
    repeat (3) @(negedge clk);
    a      = 8'hFF;
    b      = 8'hFF;
    op_sub = 1'b1;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    wait_done(5, cyc, bok);
    total++;
    if (cyc !== 9) begin
      bad++;
      $display("FAIL busy_ignore done_cycle got=%0d exp=9", cyc);
    end
    total++;
    if ({result, cout, overflow, zero} !== {8'h46, 3'b000}) begin
      bad++;
      $display("FAIL busy_ignore result_flags got=%h exp=%h", {result, cout, overflow, zero}, {8'h46, 3'b000});
    end
    @(negedge clk);
    total++;
    if ({done, busy} !== 2'b00) begin
      bad++;
      $display("FAIL done_single_pulse got=%b exp=00", {done, busy});
    end
    repeat (3) @(negedge clk);
    total++;
    if (result !== 8'h46) begin
      bad++;
      $display("FAIL result_hold_idle got=%h exp=46", result);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit bok;
    launch(8'h01, 8'h02, 1'b0);
    wait_done(1, cyc, bok);
    total++;
    if (cyc !== 9 || result !== 8'h03) begin
      bad++;
      $display("FAIL b2b_first cycle=%0d result=%h exp cycle=9 result=03", cyc, result);
    end
    launch(8'h10, 8'h01, 1'b1);
    total++;
    if ({busy, result} !== {1'b1, 8'h03}) begin
      bad++;
      $display("FAIL b2b_accept_hold got=%h exp=%h", {busy, result}, {1'b1, 8'h03});
    end
    wait_done(1, cyc, bok);
    total++;
    if (cyc !== 9 || bok !== 1'b1) begin
      bad++;
      $display("FAIL b2b_second_timing cycle=%0d busy_ok=%b exp cycle=9 busy_ok=1", cyc, bok);
    end
    total++;
    if ({result, cout, overflow, zero} !== {8'h0F, 3'b100}) begin
      bad++;
      $display("FAIL b2b_second_result got=%h exp=%h", {result, cout, overflow, zero}, {8'h0F, 3'b100});
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit bok;
    int dones;
    launch(8'h55, 8'h11, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, done, result, cout, overflow, zero} !== 13'h0) begin
      bad++;
      $display("FAIL reset_mid_outputs got=%h exp=%h", {busy, done, result, cout, overflow, zero}, 13'h0);
    end
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    total++;
    if (dones !== 0) begin
      bad++;
      $display("FAIL reset_mid_no_done got=%0d exp=0", dones);
    end
    launch(8'h10, 8'h20, 1'b0);
    wait_done(1, cyc, bok);
    total++;
    if (cyc !== 9 || bok !== 1'b1 || result !== 8'h30) begin
      bad++;
      $display("FAIL reset_mid_recover cycle=%0d busy_ok=%b result=%h exp cycle=9 busy_ok=1 result=30",
               cyc, bok, result);
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_arith();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
